// File: rtl/memwb_pipe_reg.sv
// MEM/WB pipeline register with valid/stall/flush, load alignment and extension, and WB mux.
// Optional perf counters (retired_cnt, bubble_cnt) are enabled by defining MEMWB_PERF_CNT_EN.
module memwb_pipe_reg #(
  parameter int XLEN       = 64,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall_in,
  input  logic                  flush_in,
  input  logic                  valid_in,
  input  logic [XLEN-1:0]       read_data_in,
  input  logic [XLEN-1:0]       result_alu_in,
  input  logic [REG_ADDR_W-1:0] rd_in,
  input  logic [2:0]            funct3_in,
  input  logic                  memtoreg_in,
  input  logic                  regwrite_in,
  output logic                  valid_out,
  output logic [XLEN-1:0]       readdata,
  output logic [XLEN-1:0]       result_alu_out,
  output logic [REG_ADDR_W-1:0] rd,
  output logic                  Memtoreg,
  output logic                  Regwrite,
  output logic [XLEN-1:0]       wb_data
`ifdef MEMWB_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      retired_cnt,
  output logic [CNT_W-1:0]      bubble_cnt
`endif
);

  localparam int OFF_W = $clog2(XLEN / 8);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("memwb_pipe_reg: XLEN must be 32 or 64");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("memwb_pipe_reg: CNT_W must be at least 1");
  end

  typedef struct packed {
    logic                  valid;
    logic                  regwrite;
    logic                  memtoreg;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       rdata;
    logic [XLEN-1:0]       alu;
  } stage_t;

  stage_t st_q, st_d;

  logic [OFF_W-1:0] off;
  logic [7:0]       lane_b;
  logic [15:0]      lane_h;
  logic [XLEN-1:0]  w_sext, w_zext;
  logic [XLEN-1:0]  ext_data;

  assign off    = result_alu_in[OFF_W-1:0];
  // Low offset bits below the access size are dropped, so misaligned loads read the aligned lane.
  assign lane_b = read_data_in[{off, 3'b000} +: 8];
  assign lane_h = read_data_in[{off[OFF_W-1:1], 4'b0000} +: 16];

  if (XLEN == 64) begin : g_word64
    logic [31:0] lane_w;
    assign lane_w = read_data_in[{off[OFF_W-1], 5'b00000} +: 32];
    assign w_sext = {{32{lane_w[31]}}, lane_w};
    assign w_zext = {32'd0, lane_w};
  end else begin : g_word32
    assign w_sext = read_data_in;
    assign w_zext = read_data_in;
  end

  always_comb begin
    ext_data = read_data_in;
    case (funct3_in)
      3'b000:  ext_data = {{(XLEN-8){lane_b[7]}}, lane_b};
      3'b100:  ext_data = {{(XLEN-8){1'b0}}, lane_b};
      3'b001:  ext_data = {{(XLEN-16){lane_h[15]}}, lane_h};
      3'b101:  ext_data = {{(XLEN-16){1'b0}}, lane_h};
      3'b010:  ext_data = w_sext;
      3'b110:  ext_data = w_zext;
      default: ext_data = read_data_in;
    endcase
  end

  always_comb begin
    st_d.valid    = valid_in;
    st_d.regwrite = regwrite_in & valid_in & (rd_in != '0);
    st_d.memtoreg = memtoreg_in & valid_in;
    st_d.rd       = rd_in;
    st_d.rdata    = ext_data;
    st_d.alu      = result_alu_in;
  end

  // Flush clears only the control bits; data fields are left as they were.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q <= '0;
    end else if (flush_in) begin
      st_q.valid    <= 1'b0;
      st_q.regwrite <= 1'b0;
      st_q.memtoreg <= 1'b0;
    end else if (!stall_in) begin
      st_q <= st_d;
    end
  end

  assign valid_out      = st_q.valid;
  assign Regwrite       = st_q.regwrite;
  assign Memtoreg       = st_q.memtoreg;
  assign rd             = st_q.rd;
  assign readdata       = st_q.rdata;
  assign result_alu_out = st_q.alu;
  assign wb_data        = st_q.memtoreg ? st_q.rdata : st_q.alu;

`ifdef MEMWB_PERF_CNT_EN
  logic ret_inc, bub_inc;
  assign ret_inc = !flush_in && !stall_in && valid_in;
  assign bub_inc = flush_in || (!stall_in && !valid_in);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_cnt <= '0;
      bubble_cnt  <= '0;
    end else begin
      if (ret_inc && retired_cnt != '1) retired_cnt <= retired_cnt + 1'b1;
      if (bub_inc && bubble_cnt  != '1) bubble_cnt  <= bubble_cnt + 1'b1;
    end
  end
`endif

endmodule
